seq_restoring_divider: RTL and testbench

//   Unsigned sequential restoring divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor.

---
 rtl/seq_restoring_divider_if.sv | 29 ++
 rtl/seq_restoring_divider.sv | 123 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Handshake/result bundle for seq_restoring_divider.
//   master: drives start/dividend/divisor, observes busy/done and the results.
//   slave : the divider itself.
//   Signals: start, dividend[DIVIDEND_W], divisor[DIVISOR_W] (requester -> divider);
//            busy, done, quotient[DIVIDEND_W], remainder[DIVISOR_W], div_by_zero
//            (divider -> requester).
interface seq_restoring_divider_if #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, MSB first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any division in flight
//   bus   : slave side of seq_restoring_divider_if (start/operands in; busy, done pulse,
//           quotient, remainder, div_by_zero out)
// A zero divisor is answered straight from idle with a one-cycle done, quotient all ones.
module seq_restoring_divider #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CntW = $clog2(DIVIDEND_W);

    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [DIVISOR_W-1:0]  acc_q, acc_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic                  done_q, done_d;

    // One restoring step on the current partial remainder.
    logic [DIVISOR_W:0]    part;
    logic [DIVISOR_W:0]    diff;
    logic                  qbit;
    logic [DIVISOR_W-1:0]  acc_step;
    logic [DIVIDEND_W-1:0] q_step;

    always_comb begin
        part     = {acc_q, dvd_q[DIVIDEND_W-1]};
        diff     = part - {1'b0, dsr_q};
        qbit     = (part >= {1'b0, dsr_q});
        acc_step = qbit ? diff[DIVISOR_W-1:0] : part[DIVISOR_W-1:0];
        q_step   = {q_q[DIVIDEND_W-2:0], qbit};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        acc_d       = acc_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        dvd_d   = bus.dividend;
                        dsr_d   = bus.divisor;
                        acc_d   = '0;
                        q_d     = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                    end
                end
            end
            StRun: begin
                dvd_d = dvd_q << 1;
                acc_d = acc_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DIVIDEND_W - 1)) begin
                    quotient_d  = q_step;
                    remainder_d = acc_step;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dvd_q       <= '0;
            dsr_q       <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy        = (state_q == StRun);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised + directed bench for seq_restoring_divider against a cycle-level
// arithmetic model (results from / and %, timing from the busy/done contract).
module tb_seq_restoring_divider;
    localparam int DW = 8;
    localparam int SW = 4;

    logic clk;
    logic rst_n;

    seq_restoring_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

    seq_restoring_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: idle when m_cnt==0; a run lasts DW edges, result by / and %.
    int m_cnt;
    int m_a, m_b;
    int m_q, m_r;
    bit m_done, m_busy, m_dbz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_a    <= 0;
            m_b    <= 0;
            m_q    <= 0;
            m_r    <= 0;
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt == 0) begin
                if (bus.start) begin
                    if (bus.divisor == 0) begin
                        m_done <= 1'b1;
                        m_dbz  <= 1'b1;
                        m_q    <= (1 << DW) - 1;
                        m_r    <= 0;
                    end else begin
                        m_cnt  <= DW;
                        m_a    <= int'(bus.dividend);
                        m_b    <= int'(bus.divisor);
                        m_busy <= 1'b1;
                    end
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_dbz  <= 1'b0;
                    m_q    <= m_a / m_b;
                    m_r    <= m_a % m_b;
                end
            end
        end
    end

    // Single compare process: outputs are registers, so every cycle is meaningful.
    always @(negedge clk) begin
        check("busy", int'(bus.busy), int'(m_busy));
        check("done", int'(bus.done), int'(m_done));
        check("quotient", int'(bus.quotient), m_q);
        check("remainder", int'(bus.remainder), m_r);
        check("div_by_zero", int'(bus.div_by_zero), int'(m_dbz));
    end

    // Issue one division from a negedge and wait (bounded) for done.
    task automatic run_one(input int a, input int b, input int eq, input int er,
                           input int edbz, input int elat);
        int n;
        bit got;
        bus.start    = 1'b1;
        bus.dividend = DW'(a);
        bus.divisor  = SW'(b);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        check("lit_latency", got ? n : -1, elat);
        check("lit_quotient", int'(bus.quotient), eq);
        check("lit_remainder", int'(bus.remainder), er);
        check("lit_dbz", int'(bus.div_by_zero), edbz);
        check("model_quotient", m_q, eq);
        check("model_remainder", m_r, er);
    endtask

    initial begin
        int n;
        bit got;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dbz", int'(bus.div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed results with hand-computed answers.
        run_one(200, 7, 28, 4, 0, 9);
        run_one(255, 1, 255, 0, 0, 9);
        run_one(5, 9, 0, 5, 0, 9);
        run_one(0, 15, 0, 0, 0, 9);
        run_one(100, 0, 255, 0, 1, 1);
        check("dbz_no_busy", int'(bus.busy), 0);
        run_one(15, 15, 1, 0, 0, 9);

        // Start while busy ignored; start held in done cycle accepted.
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (n == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 4'd5;
            end
            if (n == 4) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        check("ign_latency", got ? n : -1, 9);
        check("ign_quotient", int'(bus.quotient), 28);
        check("ign_remainder", int'(bus.remainder), 4);
        bus.start    = 1'b1;
        bus.dividend = 8'd144;
        bus.divisor  = 4'd12;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        check("b2b_latency", got ? n : -1, 9);
        check("b2b_quotient", int'(bus.quotient), 12);
        check("b2b_remainder", int'(bus.remainder), 0);

        // Reset mid-run aborts immediately, no done afterwards.
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", int'(bus.done), 0);
        end

        // Random operands with random gaps between requests.
        for (int i = 0; i < 200; i++) begin
            int a;
            int b;
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(15, 0));
            run_one(a, b, (b == 0) ? 255 : a / b, (b == 0) ? 0 : a % b,
                    (b == 0) ? 1 : 0, (b == 0) ? 1 : 9);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        // Exhaustive, back-to-back: next operands presented in each done cycle.
        bus.start = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.dividend = DW'(a);
                bus.divisor  = SW'(b);
                n   = 0;
                got = 1'b0;
                while (!got && n < 20) begin
                    @(negedge clk);
                    n++;
                    if (bus.done) got = 1'b1;
                end
                check("ex_latency", got ? n : -1, (b == 0) ? 1 : 9);
                check("ex_quotient", int'(bus.quotient), (b == 0) ? 255 : a / b);
                check("ex_remainder", int'(bus.remainder), (b == 0) ? 0 : a % b);
            end
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
